// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle RV32 control path: state encoding,
// opcode and ALU operation constants, plus the funct3 -> ALU operation helper.
package proc_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    // alt selects the SUB/SRA variant; callers decide when funct7[5] is honoured.
    function automatic logic [3:0] alu_funct(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/proc_fsm_alu_decode.sv
// Purely combinational decode of the latched instruction into the ALU
// operation code and the operand-B select.
module alu_decode
    import proc_pkg::*;
(
    input  logic [31:0] ir,
    output logic [3:0]  alu_ctrl,
    output logic        alu_src
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       alt_s;
    logic       unused_ir_s;

    assign opcode_s    = ir[6:0];
    assign funct3_s    = ir[14:12];
    assign alt_s       = ir[30];
    assign unused_ir_s = ^{ir[31], ir[29:15], ir[11:7]};

    // Opcode selects the operation; unknown opcodes (including ir==0) give all-zero.
    always_comb begin
        alu_ctrl = ALU_AND;
        alu_src  = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                alu_ctrl = alu_funct(funct3_s, alt_s);
                alu_src  = 1'b0;
            end
            OP_IALU: begin
                alu_ctrl = alu_funct(funct3_s, alt_s && (funct3_s == 3'b101));
                alu_src  = 1'b1;
            end
            OP_LW, OP_SW: begin
                alu_ctrl = ALU_ADD;
                alu_src  = 1'b1;
            end
            OP_BEQ: begin
                alu_ctrl = ALU_SUB;
                alu_src  = 1'b0;
            end
            default: begin
                alu_ctrl = ALU_AND;
                alu_src  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/proc_fsm.sv
// Multi-cycle control FSM (IF/ID/EX/MEM/WB/HALT). Strobes decode from the
// registered state and ir only; PCSrc additionally qualifies on the ALU zero flag.
module proc_fsm
    import proc_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        loadPC,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic [3:0]  ALUCtrl,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic [31:0] ir,
    output logic        halted,
    output logic [31:0] retired
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retired_q, retired_d;

    logic is_alu_s, is_lw_s, is_sw_s, is_beq_s;
    logic load_pc_s, pc_src_s, reg_write_s, mem_read_s, mem_write_s, mem_to_reg_s;
    logic retire_s;

    assign is_alu_s = (ir_q[6:0] == OP_RTYPE) || (ir_q[6:0] == OP_IALU);
    assign is_lw_s  = (ir_q[6:0] == OP_LW);
    assign is_sw_s  = (ir_q[6:0] == OP_SW);
    assign is_beq_s = (ir_q[6:0] == OP_BEQ);

    alu_decode u_alu_decode (
        .ir       (ir_q),
        .alu_ctrl (ALUCtrl),
        .alu_src  (ALUSrc)
    );

    // Next state, strobes and retirement; an illegal no-op pulses loadPC but is not counted.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        load_pc_s    = 1'b0;
        pc_src_s     = 1'b0;
        reg_write_s  = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        retire_s     = 1'b0;
        case (state_q)
            ST_IF: begin
                ir_d    = instr;
                state_d = ST_ID;
            end
            ST_ID: begin
                state_d = ST_EX;
            end
            ST_EX: begin
                mem_to_reg_s = is_lw_s;
                if (is_alu_s) begin
                    state_d = ST_WB;
                end else if (is_lw_s || is_sw_s) begin
                    state_d = ST_MEM;
                end else if (is_beq_s) begin
                    load_pc_s = 1'b1;
                    pc_src_s  = zero;
                    retire_s  = 1'b1;
                    state_d   = ST_IF;
                end else if (ILLEGAL_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    load_pc_s = 1'b1;
                    state_d   = ST_IF;
                end
            end
            ST_MEM: begin
                mem_to_reg_s = is_lw_s;
                if (is_lw_s) begin
                    mem_read_s = 1'b1;
                    state_d    = ST_WB;
                end else begin
                    mem_write_s = 1'b1;
                    load_pc_s   = 1'b1;
                    retire_s    = 1'b1;
                    state_d     = ST_IF;
                end
            end
            ST_WB: begin
                mem_to_reg_s = is_lw_s;
                reg_write_s  = 1'b1;
                load_pc_s    = 1'b1;
                retire_s     = 1'b1;
                state_d      = ST_IF;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IF;
            end
        endcase
        if (retire_s) begin
            retired_d = retired_q + 32'd1;
        end else begin
            retired_d = retired_q;
        end
    end

    // State, instruction register and retirement counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IF;
            ir_q      <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    assign loadPC   = load_pc_s;
    assign PCSrc    = pc_src_s;
    assign RegWrite = reg_write_s;
    assign MemRead  = mem_read_s;
    assign MemWrite = mem_write_s;
    assign MemToReg = mem_to_reg_s;
    assign ir       = ir_q;
    assign halted   = (state_q == ST_HALT);
    assign retired  = retired_q;

endmodule
